vga_pixel_pipe: RTL and testbench

Parametrised VGA timing generator and pixel output stage. It divides the system clock into a pixel-rate enable and generates horizontal and vertical counters, sync pulses and display-enable from programmable timing parameters. It exposes the current pixel coordinate to upstream renderers and returns their colour on aligned, registered RGB and sync outputs. It sits between the board clock/reset and the VGA connector, replacing the fixed 640x480 controller and blanking wrapper.

---
 rtl/vga_pixel_pipe.sv | 160 ++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: pixel-rate clock divider, programmable H/V timing counters
// and a registered RGB/sync output stage with one pixel tick of latency.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a test_mode input that
// substitutes eight vertical colour bars for the upstream colour.
module vga_pixel_pipe #(
  parameter int CLK_DIV  = 4,
  parameter int COLOR_W  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] in_r,
  input  logic [COLOR_W-1:0] in_g,
  input  logic [COLOR_W-1:0] in_b,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [10:0]        pix_x,
  output logic [10:0]        pix_y,
  output logic               pix_en,
  output logic               frame_start,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               h_sync,
  output logic               v_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  // 12-bit boundaries so an end point of exactly 2048 still compares correctly
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] H_SB  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] V_SB  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [10:0]      h_cnt_reg, h_cnt_next;
  logic [10:0]      v_cnt_reg, v_cnt_next;
  logic [11:0]      h_ext, v_ext;
  logic             de, hs_act, vs_act;
  logic             h_sync_reg, v_sync_reg;

  // With CLK_DIV=1 the counter is stuck at 0 == DIV_LAST, so pix_en is always 1
  assign pix_en = (div_cnt_reg == DIV_LAST);
  assign h_ext  = {1'b0, h_cnt_reg};
  assign v_ext  = {1'b0, v_cnt_reg};

  // Next-state for the divider and the raster counters (line wrap and
  // vertical advance happen on the same pixel tick)
  always_comb begin
    div_cnt_next = pix_en ? '0 : div_cnt_reg + 1'b1;
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 11'd1;
      end
    end
  end

  // Divider and raster counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
    end
  end

  // Stage-0 decodes of the current raster position
  always_comb begin
    de     = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_act = (h_ext >= H_SB) && (h_ext < H_SE);
    vs_act = (v_ext >= V_SB) && (v_ext < V_SE);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int          BAR_W_I = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] BAR_W   = 11'(BAR_W_I);
  logic [10:0] bar_q;
  logic [2:0]  bar_idx, bar_code;

  // Bar index from the column, clamped so the right-hand remainder stays black
  always_comb begin
    bar_q    = h_cnt_reg / BAR_W;
    bar_idx  = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
    bar_code = 3'd7 - bar_idx;
  end
`endif

  logic [COLOR_W-1:0] in_c [3];
  assign in_c[0] = in_r;
  assign in_c[1] = in_g;
  assign in_c[2] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_ch
      logic [COLOR_W-1:0] src;
      logic [COLOR_W-1:0] chan_reg;
`ifdef VGA_TEST_PATTERN_EN
      // Channel 0 (red) takes code bit 2, green bit 1, blue bit 0
      assign src = test_mode ? {COLOR_W{bar_code[2-gi]}} : in_c[gi];
`else
      assign src = in_c[gi];
`endif
      // Colour register: blanked outside the active area, loads once per pixel
      always_ff @(posedge clk or posedge reset) begin
        if (reset)       chan_reg <= '0;
        else if (pix_en) chan_reg <= de ? src : '0;
      end
    end
  endgenerate

  // Sync registers, aligned with the colour register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync_reg <= ~SYNC_ON;
      v_sync_reg <= ~SYNC_ON;
    end else if (pix_en) begin
      h_sync_reg <= hs_act ? SYNC_ON : ~SYNC_ON;
      v_sync_reg <= vs_act ? SYNC_ON : ~SYNC_ON;
    end
  end

  assign pix_x  = h_cnt_reg;
  assign pix_y  = v_cnt_reg;
  assign vga_r  = gen_ch[0].chan_reg;
  assign vga_g  = gen_ch[1].chan_reg;
  assign vga_b  = gen_ch[2].chan_reg;
  assign h_sync = h_sync_reg;
  assign v_sync = v_sync_reg;
  // Gated by reset so the pulse stays low while held in reset with CLK_DIV=1
  assign frame_start = pix_en && !reset && (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);

endmodule

// File: tb/tb_vga_pixel_pipe.sv
`timescale 1ns/1ps
// Bench for vga_pixel_pipe: a small-timing CLK_DIV=4 instance checked by a
// queue scoreboard on every clock, plus a CLK_DIV=1 tiny-timing instance.
module tb_vga_pixel_pipe;
  localparam int DIV = 4, HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;        // 24
  localparam int VT = VA + VFP + VS + VBP;        // 10
  localparam int LINE_CLKS  = HT * DIV;           // 96
  localparam int FRAME_CLKS = HT * VT * DIV;      // 960
  localparam int HT1 = 14, VT1 = 7;

  logic clk = 1'b0, rst = 1'b1, rst1 = 1'b1;
  logic [3:0] in_r = 4'h0, in_g = 4'h0, in_b = 4'h0;
  logic [3:0] in1 = 4'hF;
  logic test_mode = 1'b0;
  logic [10:0] pix_x, pix_y, pix_x1, pix_y1;
  logic pix_en, frame_start, h_sync, v_sync;
  logic pix_en1, fs1, hs1, vs1;
  logic [3:0] vga_r, vga_g, vga_b, vga1_r, vga1_g, vga1_b;

  always #5 clk = ~clk;

  vga_pixel_pipe #(.CLK_DIV(DIV), .COLOR_W(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS),
    .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)) dut (
    .clk(clk), .reset(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_x(pix_x), .pix_y(pix_y), .pix_en(pix_en), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .h_sync(h_sync), .v_sync(v_sync));

  vga_pixel_pipe #(.CLK_DIV(1), .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2),
    .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0)) dut1 (
    .clk(clk), .reset(rst1), .in_r(in1), .in_g(in1), .in_b(in1),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .pix_x(pix_x1), .pix_y(pix_y1), .pix_en(pix_en1), .frame_start(fs1),
    .vga_r(vga1_r), .vga_g(vga1_g), .vga_b(vga1_b), .h_sync(hs1), .v_sync(vs1));

  typedef struct packed {
    logic [3:0] r, g, b;
    logic       hs, vs;
  } exp_t;

  exp_t exp_q[$];
  int m_div = 0, m_x = 0, m_y = 0;
  int n_checks = 0, n_fail = 0;

  // Reference raster model: on each modelled pixel tick, push the expected
  // registered outputs for the current coordinate, then advance.
  initial begin
    exp_t e;
    logic [3:0] cr, cg, cb;
    logic [2:0] code;
    int bar;
    bit de;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_div = 0; m_x = 0; m_y = 0;
        exp_q.delete();
      end else if (m_div == DIV - 1) begin
        de = (m_x < HA) && (m_y < VA);
        cr = in_r; cg = in_g; cb = in_b;
        if (test_mode) begin
          bar = m_x / (HA / 8);
          if (bar > 7) bar = 7;
          code = 3'(7 - bar);
          cr = code[2] ? 4'hF : 4'h0;
          cg = code[1] ? 4'hF : 4'h0;
          cb = code[0] ? 4'hF : 4'h0;
        end
        e.r  = de ? cr : 4'h0;
        e.g  = de ? cg : 4'h0;
        e.b  = de ? cb : 4'h0;
        e.hs = !((m_x >= HA + HFP) && (m_x < HA + HFP + HS));
        e.vs = !((m_y >= VA + VFP) && (m_y < VA + VFP + VS));
        exp_q.push_back(e);
        m_div = 0;
        if (m_x == HT - 1) begin
          m_x = 0;
          m_y = (m_y == VT - 1) ? 0 : m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
      end else begin
        m_div = m_div + 1;
      end
    end
  end

  // Scoreboard monitor: mid-cycle, compare every main-DUT output with the model
  initial begin
    exp_t cur, e;
    bit pe_exp, fs_exp;
    int ex, ey;
    cur = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1};
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1};
        pe_exp = 1'b0; fs_exp = 1'b0; ex = 0; ey = 0;
      end else begin
        pe_exp = (m_div == DIV - 1);
        fs_exp = pe_exp && (m_x == 0) && (m_y == 0);
        ex = m_x; ey = m_y;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      e = cur;
      n_checks++;
      if (pix_x !== 11'(ex) || pix_y !== 11'(ey)) begin
        n_fail++;
        $display("FAIL sb_coord t=%0t got (%0d,%0d) expected (%0d,%0d)", $time, pix_x, pix_y, ex, ey);
      end
      n_checks++;
      if (pix_en !== pe_exp || frame_start !== fs_exp) begin
        n_fail++;
        $display("FAIL sb_tick t=%0t got pix_en=%b fs=%b expected pix_en=%b fs=%b", $time, pix_en, frame_start, pe_exp, fs_exp);
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== {e.r, e.g, e.b}) begin
        n_fail++;
        $display("FAIL sb_rgb t=%0t got %h%h%h expected %h%h%h", $time, vga_r, vga_g, vga_b, e.r, e.g, e.b);
      end
      n_checks++;
      if (h_sync !== e.hs || v_sync !== e.vs) begin
        n_fail++;
        $display("FAIL sb_sync t=%0t got hs=%b vs=%b expected hs=%b vs=%b", $time, h_sync, v_sync, e.hs, e.vs);
      end
    end
  end

  // Measures one low pulse and the fall-to-fall period of a sync (no checking)
  task automatic measure(input bit use_v, input int bound, output int low, output int per,
                         output int fs_cnt, output int y_at_fall);
    logic prev, cur;
    bit found = 0;
    low = 0; per = 0; fs_cnt = 0; y_at_fall = -1;
    prev = use_v ? v_sync : h_sync;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      cur = use_v ? v_sync : h_sync;
      if (prev === 1'b1 && cur === 1'b0) begin found = 1; break; end
      prev = cur;
    end
    if (!found) return;
    y_at_fall = int'(pix_y);
    low = 1; prev = 1'b0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      cur = use_v ? v_sync : h_sync;
      if (frame_start === 1'b1) fs_cnt++;
      if (prev === 1'b1 && cur === 1'b0) begin per = k; break; end
      if (cur === 1'b0 && prev === 1'b0) low++;
      prev = cur;
    end
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h0 || h_sync !== 1'b1 || v_sync !== 1'b1 ||
        pix_x !== 11'd0 || pix_y !== 11'd0 || pix_en !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rgb=%h%h%h hs=%b vs=%b xy=(%0d,%0d) en=%b expected 000 1 1 (0,0) 0",
               vga_r, vga_g, vga_b, h_sync, v_sync, pix_x, pix_y, pix_en);
    end
    rst = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (pix_en === 1'b1) break;
    end
    n_checks++;
    if (k + 1 != DIV) begin
      n_fail++;
      $display("FAIL first_tick got tick on clk %0d expected clk %0d", k + 1, DIV);
    end
    $display("test_reset: first tick on clk %0d after release", k + 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      in_r = 4'($urandom); in_g = 4'($urandom); in_b = 4'($urandom);
    end
    n_checks++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL sb_depth got %0d pending expected <=1", exp_q.size());
    end
    $display("test_random: 600 clocks of random colour");
  endtask

  task automatic test_h_timing();
    int low, per, fs, y;
    measure(1'b0, 4 * LINE_CLKS, low, per, fs, y);
    n_checks++;
    if (low != HS * DIV) begin
      n_fail++;
      $display("FAIL h_sync_width got %0d clks expected %0d", low, HS * DIV);
    end
    n_checks++;
    if (per != LINE_CLKS) begin
      n_fail++;
      $display("FAIL h_line_period got %0d clks expected %0d", per, LINE_CLKS);
    end
    $display("test_h_timing: hsync low %0d clks, period %0d clks", low, per);
  endtask

  task automatic test_v_timing();
    int low, per, fs, y;
    measure(1'b1, 3 * FRAME_CLKS, low, per, fs, y);
    n_checks++;
    if (low != VS * LINE_CLKS) begin
      n_fail++;
      $display("FAIL v_sync_width got %0d clks expected %0d", low, VS * LINE_CLKS);
    end
    n_checks++;
    if (per != FRAME_CLKS) begin
      n_fail++;
      $display("FAIL v_frame_period got %0d clks expected %0d", per, FRAME_CLKS);
    end
    n_checks++;
    if (y != VA + VFP) begin
      n_fail++;
      $display("FAIL v_sync_line got line %0d expected %0d", y, VA + VFP);
    end
    n_checks++;
    if (fs != 1) begin
      n_fail++;
      $display("FAIL frame_start_count got %0d expected 1", fs);
    end
    $display("test_v_timing: vsync low %0d clks, frame %0d clks, frame_start %0d", low, per, fs);
  endtask

  // Counts clocks over one frame window on which the predicate-selected
  // colour pattern is present on the outputs
  task automatic count_frame(output int n_r, output int n_g, output int n_ffo, output int n_all);
    int k = 0;
    n_r = 0; n_g = 0; n_ffo = 0; n_all = 0;
    while (k < 2 * FRAME_CLKS && frame_start !== 1'b1) begin @(negedge clk); k++; end
    for (int i = 0; i < FRAME_CLKS; i++) begin
      @(negedge clk);
      if (vga_r === 4'hF) n_r++;
      if (vga_g === 4'hF) n_g++;
      if ({vga_r, vga_g, vga_b} === 12'hFF0) n_ffo++;
      if ({vga_r, vga_g, vga_b} === 12'hFFF) n_all++;
    end
  endtask

  task automatic test_blanking();
    int n_r, n_g, n_ffo, n_all;
    @(negedge clk);
    in_r = 4'hF; in_g = 4'hF; in_b = 4'hF;
    count_frame(n_r, n_g, n_ffo, n_all);
    n_checks++;
    if (n_all != HA * VA * DIV) begin
      n_fail++;
      $display("FAIL blank_active_clks got %0d expected %0d", n_all, HA * VA * DIV);
    end
    $display("test_blanking: %0d clks of white per frame", n_all);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int n_r, n_g, n_ffo, n_all;
    @(negedge clk);
    test_mode = 1'b1;
    in_r = 4'h5; in_g = 4'hA; in_b = 4'h3;
    count_frame(n_r, n_g, n_ffo, n_all);
    // bar width 2: red/green/white/yellow pixel counts per line follow the bar codes
    n_checks++;
    if (n_r != 8 * VA * DIV || n_g != 8 * VA * DIV) begin
      n_fail++;
      $display("FAIL pattern_rg got r=%0d g=%0d expected %0d each", n_r, n_g, 8 * VA * DIV);
    end
    n_checks++;
    if (n_ffo != 2 * VA * DIV || n_all != 2 * VA * DIV) begin
      n_fail++;
      $display("FAIL pattern_bars got yellow=%0d white=%0d expected %0d each", n_ffo, n_all, 2 * VA * DIV);
    end
    @(negedge clk);
    test_mode = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      in_r = 4'($urandom); in_g = 4'($urandom); in_b = 4'($urandom);
    end
    $display("test_pattern: yellow=%0d white=%0d clks", n_ffo, n_all);
  endtask
`endif

  task automatic test_reset_midframe();
    int k = 0;
    while (k < 2 * FRAME_CLKS && !(v_sync === 1'b0 && pix_x > 11'd5)) begin @(negedge clk); k++; end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h0 || h_sync !== 1'b1 || v_sync !== 1'b1 ||
        pix_x !== 11'd0 || pix_y !== 11'd0 || pix_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got rgb=%h%h%h hs=%b vs=%b xy=(%0d,%0d) en=%b expected 000 1 1 (0,0) 0",
               vga_r, vga_g, vga_b, h_sync, v_sync, pix_x, pix_y, pix_en);
    end
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (pix_en === 1'b1) break;
    end
    n_checks++;
    if (k + 1 != DIV || pix_x !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_restart got tick clk %0d x=%0d expected clk %0d x=0", k + 1, pix_x, DIV);
    end
    repeat (2 * LINE_CLKS) @(negedge clk);
    $display("test_reset_midframe: restarted from (0,0)");
  endtask

  task automatic test_clk_div1();
    int ex, ey, px, py, k;
    @(negedge clk);
    n_checks++;
    if (pix_en1 !== 1'b1 || fs1 !== 1'b0 || pix_x1 !== 11'd0 || {vga1_r, vga1_g, vga1_b} !== 12'h0 ||
        hs1 !== 1'b1 || vs1 !== 1'b1) begin
      n_fail++;
      $display("FAIL div1_reset got en=%b fs=%b x=%0d rgb=%h%h%h hs=%b vs=%b expected 1 0 0 000 1 1",
               pix_en1, fs1, pix_x1, vga1_r, vga1_g, vga1_b, hs1, vs1);
    end
    rst1 = 1'b0;
    for (int kk = 1; kk <= 2 * HT1 * VT1 + 3; kk++) begin
      @(negedge clk);
      ex = kk % HT1; ey = (kk / HT1) % VT1;
      px = (kk - 1) % HT1; py = ((kk - 1) / HT1) % VT1;
      n_checks++;
      if (pix_x1 !== 11'(ex) || pix_y1 !== 11'(ey) || pix_en1 !== 1'b1 || fs1 !== (ex == 0 && ey == 0)) begin
        n_fail++;
        $display("FAIL div1_raster clk %0d got (%0d,%0d) en=%b fs=%b expected (%0d,%0d) 1 %b",
                 kk, pix_x1, pix_y1, pix_en1, fs1, ex, ey, (ex == 0 && ey == 0));
      end
      n_checks++;
      if (vga1_r !== ((px < 8 && py < 4) ? 4'hF : 4'h0) || hs1 !== !(px >= 10 && px < 12) || vs1 !== (py != 5)) begin
        n_fail++;
        $display("FAIL div1_out clk %0d for (%0d,%0d) got r=%h hs=%b vs=%b", kk, px, py, vga1_r, hs1, vs1);
      end
    end
    k = 0;
    while (k < 2 * HT1 * VT1 && !(pix_x1 === 11'd5 && pix_y1 === 11'd2)) begin @(negedge clk); k++; end
    #1 rst1 = 1'b1;
    #1;
    n_checks++;
    if (pix_x1 !== 11'd0 || pix_y1 !== 11'd0 || {vga1_r, vga1_g, vga1_b} !== 12'h0 || hs1 !== 1'b1 ||
        vs1 !== 1'b1 || fs1 !== 1'b0 || pix_en1 !== 1'b1) begin
      n_fail++;
      $display("FAIL div1_midreset got (%0d,%0d) rgb=%h%h%h hs=%b vs=%b fs=%b en=%b expected (0,0) 000 1 1 0 1",
               pix_x1, pix_y1, vga1_r, vga1_g, vga1_b, hs1, vs1, fs1, pix_en1);
    end
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pix_x1 !== 11'd1 || pix_y1 !== 11'd0 || vga1_r !== 4'hF) begin
      n_fail++;
      $display("FAIL div1_restart got (%0d,%0d) r=%h expected (1,0) F", pix_x1, pix_y1, vga1_r);
    end
    $display("test_clk_div1: raster and mid-frame reset exercised");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_random();
    test_h_timing();
    test_v_timing();
    test_blanking();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    test_reset_midframe();
    test_clk_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
